cim_tile_arbiter: RTL and testbench

//  Shares one bank of CIM tiles (V_CIM_TILES x BUS_WIDTH input bus) between NUM_REQ fc layer controllers.

---
 rtl/cim_tile_arbiter_if.sv | 34 +++
 rtl/cim_tile_arbiter.sv | 144 ++++++++++++++
 tb/tb_cim_tile_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cim_tile_arbiter_if.sv
// Shared CIM tile bus between the layer controllers and the tile arbiter.
// The arbiter takes the slave modport; the requester/tile side takes master.
interface cim_tile_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 16,
  parameter int V_CIM_TILES = 8,
  parameter int ADDR_W      = 5
);
  localparam int DATA_W = BUS_WIDTH * V_CIM_TILES;

  logic [NUM_REQ-1:0]             i_req;
  logic [NUM_REQ-1:0]             i_release;
  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]             i_req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ-1:0]             o_grant;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic                           i_cim_ready;
  logic [DATA_W-1:0]              o_cim_data;
  logic                           o_cim_we;
  logic [ADDR_W-1:0]              o_cim_rd_addr;
  logic                           o_busy;
  logic                           o_timeout;

  modport master (
    output i_req, i_release, i_req_data, i_req_we, i_req_addr, i_cim_ready,
    input  o_grant, o_req_ready, o_cim_data, o_cim_we, o_cim_rd_addr, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_release, i_req_data, i_req_we, i_req_addr, i_cim_ready,
    output o_grant, o_req_ready, o_cim_data, o_cim_we, o_cim_rd_addr, o_busy, o_timeout
  );
endinterface

// File: rtl/cim_tile_arbiter.sv
// Round-robin owner arbitration for one shared bank of CIM tiles, with
// drain-before-handover and an idle-hold timeout that forces a release.
module cim_tile_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 16,
  parameter int V_CIM_TILES = 8,
  parameter int ADDR_W      = 5,
  parameter int HOLD_MAX    = 255
) (
  input  logic              clk,
  input  logic              rst,
  cim_tile_arbiter_if.slave bus
);
  localparam int DATA_W = BUS_WIDTH * V_CIM_TILES;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX : 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [HOLD_W-1:0]  holdCnt_q;
  logic               timeout_q;

  logic [HOLD_W-1:0]  holdCnt_d;
  logic [PTR_W-1:0]   winIdx_d;
  logic [NUM_REQ-1:0] winOh_d;
  logic [PTR_W-1:0]   scanIdx;

  logic anyReq;
  logic ownerReq;
  logic ownerRel;
  logic ownerWe;
  logic holdHit;
  logic leaveReq;

  logic [DATA_W-1:0] cimData;
  logic [ADDR_W-1:0] cimAddr;

  assign anyReq   = |bus.i_req;
  assign ownerReq = |(grant_q & bus.i_req);
  assign ownerRel = |(grant_q & bus.i_release);
  assign ownerWe  = |(grant_q & bus.i_req_we);
  assign leaveReq = ownerRel || !ownerReq;

  // Scan from ptr+NUM_REQ down to ptr+1 so the closest set bit after ptr wins.
  always_comb begin
    winIdx_d = ptr_q;
    winOh_d  = '0;
    scanIdx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scanIdx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.i_req[scanIdx]) begin
        winIdx_d = scanIdx;
      end
    end
    winOh_d[winIdx_d] = 1'b1;
  end

  always_comb begin
    holdCnt_d = holdCnt_q;
    if (ownerWe) begin
      holdCnt_d = '0;
    end else if (bus.i_cim_ready && (holdCnt_q != HOLD_SAT)) begin
      holdCnt_d = holdCnt_q + HOLD_W'(1);
    end
  end

  assign holdHit = (HOLD_MAX > 0) && (holdCnt_d == HOLD_SAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          holdCnt_q <= '0;
          if (anyReq) begin
            state_q <= GRANT;
            grant_q <= winOh_d;
            ptr_q   <= winIdx_d;
          end
        end
        GRANT: begin
          // A voluntary or implicit release takes precedence over the timeout.
          if (leaveReq || holdHit) begin
            state_q   <= DRAIN;
            grant_q   <= '0;
            holdCnt_q <= '0;
            timeout_q <= !leaveReq;
          end else begin
            holdCnt_q <= holdCnt_d;
          end
        end
        DRAIN: begin
          holdCnt_q <= '0;
          if (bus.i_cim_ready) begin
            if (anyReq) begin
              state_q <= GRANT;
              grant_q <= winOh_d;
              ptr_q   <= winIdx_d;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // grant_q is zero outside GRANT and clears asynchronously, so the AND-OR
  // mux blanks the tile bus whenever there is no owner.
  always_comb begin
    cimData = '0;
    cimAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cimData = cimData | (bus.i_req_data[i] & {DATA_W{grant_q[i]}});
      cimAddr = cimAddr | (bus.i_req_addr[i] & {ADDR_W{grant_q[i]}});
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_req_ready   = grant_q & {NUM_REQ{bus.i_cim_ready}};
  assign bus.o_cim_data    = cimData;
  assign bus.o_cim_we      = ownerWe;
  assign bus.o_cim_rd_addr = cimAddr;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_cim_tile_arbiter.sv
// Bench for cim_tile_arbiter: expected grants are queued as requests are
// driven and popped by a monitor whenever a new owner appears.
module tb_cim_tile_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int BUS_WIDTH   = 16;
  localparam int V_CIM_TILES = 8;
  localparam int ADDR_W      = 5;
  localparam int HOLD_MAX    = 4;
  localparam int DATA_W      = BUS_WIDTH * V_CIM_TILES;

  logic clk = 1'b0;
  logic rst;

  int checks      = 0;
  int failures    = 0;
  int timeoutSeen = 0;

  logic [NUM_REQ-1:0] expQ[$];
  logic [NUM_REQ-1:0] prevGrant = '0;
  logic [DATA_W-1:0]  pattern[NUM_REQ];

  cim_tile_arbiter_if #(
    .NUM_REQ(NUM_REQ), .BUS_WIDTH(BUS_WIDTH), .V_CIM_TILES(V_CIM_TILES), .ADDR_W(ADDR_W)
  ) bus ();

  cim_tile_arbiter #(
    .NUM_REQ(NUM_REQ), .BUS_WIDTH(BUS_WIDTH), .V_CIM_TILES(V_CIM_TILES),
    .ADDR_W(ADDR_W), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] rel,
                               input logic ready);
    bus.i_req       = req;
    bus.i_release   = rel;
    bus.i_cim_ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input int idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    expQ.push_back(oh);
  endtask

  // Scoreboard monitor: every new owner must match the oldest queued grant.
  always @(negedge clk) begin
    if (!rst && (bus.o_grant != '0) && (prevGrant == '0)) begin
      if (expQ.size() == 0) checkOutput("sb_unexpected_grant", DATA_W'(bus.o_grant), '0);
      else checkOutput("sb_grant_order", DATA_W'(bus.o_grant), DATA_W'(expQ.pop_front()));
    end
    if (!rst && bus.o_timeout) timeoutSeen++;
    prevGrant = bus.o_grant;
  end

  initial begin
    logic [NUM_REQ-1:0] relOh;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int t = 0; t < V_CIM_TILES; t++) begin
        pattern[i][t*BUS_WIDTH +: BUS_WIDTH] = BUS_WIDTH'((i + 1) * 16'h1357 + t);
      end
      bus.i_req_data[i] = pattern[i];
      bus.i_req_addr[i] = ADDR_W'(i + 1);
    end
    bus.i_req_we = '0;
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", DATA_W'(bus.o_grant), '0);
    checkOutput("rst_busy", DATA_W'(bus.o_busy), '0);
    checkOutput("rst_timeout", DATA_W'(bus.o_timeout), '0);
    checkOutput("rst_we", DATA_W'(bus.o_cim_we), '0);
    checkOutput("rst_data", bus.o_cim_data, '0);
    checkOutput("rst_ready", DATA_W'(bus.o_req_ready), '0);

    // Reset leaves ptr at the last requester, so req 1 beats req 2.
    rst = 1'b0;
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    expectGrant(1);
    step();
    @(negedge clk);
    checkOutput("t1_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0010));
    checkOutput("t1_busy", DATA_W'(bus.o_busy), DATA_W'(1'b1));
    checkOutput("t1_data", bus.o_cim_data, pattern[1]);
    checkOutput("t1_addr", DATA_W'(bus.o_cim_rd_addr), DATA_W'(2));
    checkOutput("t1_ready_gated", DATA_W'(bus.o_req_ready), '0);

    step();
    applyStimulus(4'b0100, 4'b0010, 1'b0);
    expectGrant(2);
    step();
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t2_drain_grant", DATA_W'(bus.o_grant), '0);
      checkOutput("t2_drain_busy", DATA_W'(bus.o_busy), DATA_W'(1'b1));
      step();
    end
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t2_ready_cycle_grant", DATA_W'(bus.o_grant), '0);
    step();
    @(negedge clk);
    checkOutput("t2_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0100));

    step();
    applyStimulus(4'b1100, 4'b0000, 1'b1);
    bus.i_req_we      = 4'b1100;
    bus.i_req_addr[2] = ADDR_W'(5);
    bus.i_req_addr[3] = ADDR_W'(9);
    @(negedge clk);
    checkOutput("t5_we", DATA_W'(bus.o_cim_we), DATA_W'(1'b1));
    checkOutput("t5_addr", DATA_W'(bus.o_cim_rd_addr), DATA_W'(5));
    checkOutput("t5_data", bus.o_cim_data, pattern[2]);
    checkOutput("t5_ready_owner_only", DATA_W'(bus.o_req_ready), DATA_W'(4'b0100));

    // Owner 2 releases while still requesting: release wins, 0 goes next.
    step();
    applyStimulus(4'b0101, 4'b0100, 1'b1);
    bus.i_req_we = '0;
    expectGrant(0);
    step();
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t5_drain_grant", DATA_W'(bus.o_grant), '0);
    checkOutput("t5_drain_we", DATA_W'(bus.o_cim_we), '0);
    checkOutput("t5_drain_addr", DATA_W'(bus.o_cim_rd_addr), '0);
    step();
    @(negedge clk);
    checkOutput("t5_rr_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0001));

    step();
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    expectGrant(2);
    step();
    step();
    @(negedge clk);
    checkOutput("implicit_rel_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0100));
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    step();
    step();
    @(negedge clk);
    checkOutput("idle_busy", DATA_W'(bus.o_busy), '0);

    step();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    bus.i_req_we = 4'b1000;
    expectGrant(3);
    step();
    @(negedge clk);
    checkOutput("t6_we_before_rst", DATA_W'(bus.o_cim_we), DATA_W'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_grant", DATA_W'(bus.o_grant), '0);
    checkOutput("t6_rst_we", DATA_W'(bus.o_cim_we), '0);
    checkOutput("t6_rst_busy", DATA_W'(bus.o_busy), '0);
    checkOutput("t6_rst_data", bus.o_cim_data, '0);
    checkOutput("t6_rst_addr", DATA_W'(bus.o_cim_rd_addr), '0);
    bus.i_req_we = '0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) expectGrant(k % NUM_REQ);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Everyone requests; each owner releases in its second grant cycle.
    for (int k = 0; k < 5; k++) begin
      step();
      relOh = '0;
      relOh[k % NUM_REQ] = 1'b1;
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, relOh, 1'b1);
      step();
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 1'b1);
      step();
    end
    @(negedge clk);
    checkOutput("t3_idle_busy", DATA_W'(bus.o_busy), '0);

    step();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    expectGrant(0);
    expectGrant(1);
    step();
    applyStimulus(4'b0011, 4'b0010, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("t4_hold_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0001));
      checkOutput("t4_hold_timeout", DATA_W'(bus.o_timeout), '0);
      step();
      applyStimulus(4'b0011, 4'b0000, 1'b1);
    end
    @(negedge clk);
    checkOutput("t4_timeout_pulse", DATA_W'(bus.o_timeout), DATA_W'(1'b1));
    checkOutput("t4_drain_grant", DATA_W'(bus.o_grant), '0);
    checkOutput("t4_drain_busy", DATA_W'(bus.o_busy), DATA_W'(1'b1));
    step();
    @(negedge clk);
    checkOutput("t4_next_grant", DATA_W'(bus.o_grant), DATA_W'(4'b0010));
    checkOutput("t4_timeout_cleared", DATA_W'(bus.o_timeout), '0);
    step();
    applyStimulus(4'b0000, 4'b0010, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    step();
    @(negedge clk);
    checkOutput("t4_idle_busy", DATA_W'(bus.o_busy), '0);

    checkOutput("sb_drained", DATA_W'(expQ.size()), '0);
    checkOutput("timeout_pulse_count", DATA_W'(timeoutSeen), DATA_W'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
